// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg
// Shared definitions for the push-button step controller: the press FSM
// state encoding, the default timing parameters and a saturating
// increment helper for the 8-bit internal counters.
package count_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_HOLD    = 2'b01,
        ST_REPEAT  = 2'b10,
        ST_LOCKOUT = 2'b11
    } state_t;

    localparam int DEBOUNCE_DEF      = 4;
    localparam int HOLD_DELAY_DEF    = 16;
    localparam int REPEAT_PERIOD_DEF = 4;

    // Counters stick at 8'hFF instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/count_ctrl_debounce.sv
// count_ctrl_debounce
// Two-flop synchroniser followed by a stability counter for one raw button.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   btn_raw  asynchronous raw button input
//   level    debounced level (registered)
module count_ctrl_debounce
    import count_ctrl_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level
);

    localparam logic [7:0] THRESH = 8'(DEBOUNCE - 1);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       level_q, level_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = 8'd0;
        // Any sample matching the current level leaves cnt_d at zero.
        if (sync2_q != level_q) begin
            if (cnt_q >= THRESH) begin
                level_d = sync2_q;
            end else begin
                cnt_d = sat_inc(cnt_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/count_ctrl.sv
// count_ctrl
// Turns two raw up/down pushbuttons into single-cycle step requests for a
// downstream up/down counter, with hold-to-auto-repeat and a lockout when
// both buttons are pressed.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   btn_up     raw up button
//   btn_down   raw down button
//   enable     one-cycle step request (registered)
//   direction  1 = up, 0 = down; holds its value between pulses (registered)
//   busy       any button debounced-pressed (registered)
//
// state      | meaning
// IDLE       | no button pressed, waiting for a single press
// HOLD       | press accepted, first step sent, timing hold delay
// REPEAT     | auto-repeat, one step every REPEAT_PERIOD cycles
// LOCKOUT    | both buttons seen, silent until both released
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int DEBOUNCE      = DEBOUNCE_DEF,
    parameter int HOLD_DELAY    = HOLD_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    output logic enable,
    output logic direction,
    output logic busy
);

    localparam logic [7:0] HOLD_TH = 8'(HOLD_DELAY - 1);
    localparam logic [7:0] REP_TH  = 8'(REPEAT_PERIOD - 1);

    logic up_lvl, dn_lvl;

    count_ctrl_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_up (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_up),
        .level   (up_lvl)
    );

    count_ctrl_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_dn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_down),
        .level   (dn_lvl)
    );

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       enable_q, enable_d;
    logic       direction_q, direction_d;
    logic       busy_q, busy_d;
    logic       active_lvl, other_lvl;

    // The button that started the press is the one direction_q names.
    assign active_lvl = direction_q ? up_lvl : dn_lvl;
    assign other_lvl  = direction_q ? dn_lvl : up_lvl;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        enable_d    = 1'b0;
        direction_d = direction_q;
        busy_d      = up_lvl | dn_lvl;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (up_lvl && dn_lvl) begin
                    state_d = ST_LOCKOUT;
                end else if (up_lvl || dn_lvl) begin
                    state_d     = ST_HOLD;
                    enable_d    = 1'b1;
                    direction_d = up_lvl;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (other_lvl) begin
                    state_d = ST_LOCKOUT;
                    cnt_d   = 8'd0;
                end else if (!active_lvl) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if ((cnt_q >= ((state_q == ST_HOLD) ? HOLD_TH : REP_TH))
                             && !enable_q) begin
                    // The !enable_q guard keeps pulses at least two cycles
                    // apart even with a period or delay of one.
                    state_d  = ST_REPEAT;
                    enable_d = 1'b1;
                    cnt_d    = 8'd0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_LOCKOUT: begin
                cnt_d = 8'd0;
                if (!up_lvl && !dn_lvl) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            enable_q    <= 1'b0;
            direction_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            enable_q    <= enable_d;
            direction_q <= direction_d;
            busy_q      <= busy_d;
        end
    end

    assign enable    = enable_q;
    assign direction = direction_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl
// Directed bench for count_ctrl. Output histories are captured as bit masks
// indexed by rising-edge number (edge 1 = first edge sampling the new input
// values) and compared against hand-derived constants.
module tb_count_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic btn_up, btn_down;
    logic enable, direction, busy;
    logic btn_f;
    logic en_f, dir_f, busy_f;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    count_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .enable    (enable),
        .direction (direction),
        .busy      (busy)
    );

    count_ctrl #(.DEBOUNCE(1), .HOLD_DELAY(16), .REPEAT_PERIOD(1)) dut_f (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn_f),
        .btn_down  (1'b0),
        .enable    (en_f),
        .direction (dir_f),
        .busy      (busy_f)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, output logic [63:0] en_m,
                       output logic [63:0] dir_m, output logic [63:0] busy_m);
        en_m   = '0;
        dir_m  = '0;
        busy_m = '0;
        for (int k = 1; k <= n; k++) begin
            tick();
            en_m[k]   = enable;
            dir_m[k]  = direction;
            busy_m[k] = busy;
        end
    endtask

    logic [63:0] en_m, dir_m, busy_m, exp_m;
    int          viol, pulses, ds_cnt;
    logic        prev_en;

    initial begin
        rst      = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_f    = 1'b0;
        tick();
        tick();
        chk("rst_enable", 64'(enable), 64'd0);
        chk("rst_direction", 64'(direction), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick();

        // Single short press: one pulse at edge 7, busy 7..10, drops 7 after release.
        btn_up = 1'b1;
        run(10, en_m, dir_m, busy_m);
        chk("t1_press_en", en_m, 64'h80);
        chk("t1_dir_at_pulse", 64'(dir_m[7]), 64'd1);
        chk("t1_press_busy", busy_m, 64'h780);
        btn_up = 1'b0;
        run(10, en_m, dir_m, busy_m);
        chk("t1_rel_en", en_m, 64'h0);
        chk("t1_rel_busy", busy_m, 64'h7E);

        // 3-cycle glitch on down: filtered out.
        btn_down = 1'b1;
        tick();
        tick();
        tick();
        btn_down = 1'b0;
        run(12, en_m, dir_m, busy_m);
        chk("t2_glitch_en", en_m, 64'h0);
        chk("t2_glitch_busy", busy_m, 64'h0);

        // Long press: 7, 23, then every 4; one more at +3 during release debounce.
        btn_up = 1'b1;
        run(40, en_m, dir_m, busy_m);
        exp_m = (64'd1 << 7) | (64'd1 << 23) | (64'd1 << 27) | (64'd1 << 31)
              | (64'd1 << 35) | (64'd1 << 39);
        chk("t3_repeat_en", en_m, exp_m);
        chk("t3_repeat_dir", dir_m, 64'h1FF_FFFF_FFFE);
        btn_up = 1'b0;
        run(12, en_m, dir_m, busy_m);
        chk("t3_rel_en", en_m, 64'h8);

        // Both together: lockout until both released.
        btn_up   = 1'b1;
        btn_down = 1'b1;
        run(20, en_m, dir_m, busy_m);
        chk("t4_both_en", en_m, 64'h0);
        btn_down = 1'b0;
        run(12, en_m, dir_m, busy_m);
        chk("t4_down_rel_en", en_m, 64'h0);
        chk("t4_down_rel_busy", busy_m, 64'h1FFE);
        btn_up = 1'b0;
        run(12, en_m, dir_m, busy_m);
        chk("t4_all_rel_en", en_m, 64'h0);
        btn_up = 1'b1;
        run(10, en_m, dir_m, busy_m);
        chk("t4_repress_en", en_m, 64'h80);
        btn_up = 1'b0;
        run(12, en_m, dir_m, busy_m);
        chk("t4_repress_rel_en", en_m, 64'h0);

        // Down held into REPEAT, then reset right where a pulse would fire.
        btn_down = 1'b1;
        run(30, en_m, dir_m, busy_m);
        exp_m = (64'd1 << 7) | (64'd1 << 23) | (64'd1 << 27);
        chk("t5_down_en", en_m, exp_m);
        chk("t5_down_dir_on_pulse", en_m & dir_m, 64'h0);
        rst = 1'b1;
        tick();
        chk("t5_rst_enable", 64'(enable), 64'd0);
        chk("t5_rst_direction", 64'(direction), 64'd1);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        run(10, en_m, dir_m, busy_m);
        chk("t5_post_rst_en", en_m, 64'h80);
        chk("t5_post_rst_dir", dir_m, 64'h7E);
        btn_down = 1'b0;
        run(12, en_m, dir_m, busy_m);

        // DEBOUNCE=1, REPEAT_PERIOD=1: pulses at 4, 20, then every other edge.
        btn_f   = 1'b1;
        prev_en = 1'b0;
        viol    = 0;
        pulses  = 0;
        ds_cnt  = 0;
        en_m    = '0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            en_m[k] = en_f;
            if (en_f && prev_en) viol++;
            if (en_f) begin
                pulses++;
                ds_cnt = dir_f ? ds_cnt + 1 : ds_cnt - 1;
            end
            prev_en = en_f;
        end
        exp_m = (64'd1 << 4) | (64'd1 << 20);
        for (int k = 22; k <= 40; k += 2) exp_m |= (64'd1 << k);
        chk("t6_fast_en", en_m, exp_m);
        chk("t6_fast_back_to_back", 64'(viol), 64'd0);
        chk("t6_fast_counter", 64'(ds_cnt), 64'd12);
        btn_f = 1'b0;
        run(8, en_m, dir_m, busy_m);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/count_ctrl.md
COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 Parameter DEBOUNCE, default 4: consecutive stable synchronised samples required before a debounced level changes; legal range 1-255.
REQ-002 Parameter HOLD_DELAY, default 16: cycles a debounced press is held before auto-repeat starts; legal range 1-255.
REQ-003 Parameter REPEAT_PERIOD, default 4: cycles between auto-repeat pulses; legal range 1-255.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 btn_up  input  1  raw asynchronous up pushbutton, active-high.
REQ-007 btn_down  input  1  raw asynchronous down pushbutton, active-high.
REQ-008 enable  output  1  registered one-cycle step request to the downstream up/down counter.
REQ-009 direction  output  1  registered; 1 = count up, 0 = count down; valid whenever enable=1.
REQ-010 busy  output  1  registered; high while any button is debounced-pressed.

Function
REQ-011 Each button SHALL pass through a 2-flop synchroniser before any other logic.
REQ-012 Each debounced level SHALL change only after the synchronised input differs from it for DEBOUNCE consecutive cycles; any sample equal to the current level SHALL clear the stability count.
REQ-013 With a button held stable, enable SHALL assert exactly 2+DEBOUNCE+1 rising edges after the first edge sampling it high (7 edges at defaults).
REQ-014 Press FSM states: IDLE, HOLD, REPEAT, LOCKOUT; 2-bit encoding.
REQ-015 IDLE -> HOLD on exactly one debounced button rising; enable=1 for one cycle, direction = 1 for up, 0 for down.
REQ-016 HOLD: count cycles; at HOLD_DELAY cycles go to REPEAT and emit one pulse in the pressed direction.
REQ-017 REPEAT: emit one pulse every REPEAT_PERIOD cycles while the button stays pressed.
REQ-018 HOLD or REPEAT -> IDLE on release of the active button, with no pulse in the release cycle.
REQ-019 Both buttons debounced-pressed in the same cycle, or the second pressed while in HOLD/REPEAT: go to LOCKOUT, no pulses.
REQ-020 LOCKOUT -> IDLE only when both debounced levels are 0.
REQ-021 direction SHALL keep its last value when enable=0 and SHALL never change in a cycle where enable=1 relative to the pulse it qualifies.
REQ-022 enable SHALL never be high for two consecutive cycles (holds for REPEAT_PERIOD=1 too: minimum spacing 2 cycles).
REQ-023 Internal counters 8 bits, saturating, never wrap.
REQ-024 busy = OR of the debounced levels, registered.

Reset
REQ-025 On rst=1 at a rising edge: enable=0, direction=1, busy=0, FSM=IDLE, synchronisers, debounced levels and all counters =0.
REQ-026 rst asserted mid-HOLD/REPEAT SHALL abort with no further pulse; after release, a still-held button SHALL be treated as a new press (full REQ-013 latency).
REQ-027 rst SHALL take priority over every other input in the same cycle.

Structure
REQ-028 Package count_ctrl_pkg SHALL hold the FSM state typedef/encodings and the default DEBOUNCE/HOLD_DELAY/REPEAT_PERIOD constants.
REQ-029 Sub-module debounce (synchroniser + stability counter, parameter DEBOUNCE) SHALL be instantiated once per button.
REQ-030 Outputs connect directly to the up/down counter's enable/direction ports, with no glue logic.

Verification (defaults unless stated)
REQ-031 btn_up held 10 cycles then released -> exactly one enable pulse, 7 edges after press, direction=1; busy falls 7 edges after release.
REQ-032 btn_down glitch high for 3 cycles -> no enable, busy stays 0.
REQ-033 btn_up held 40 cycles -> first pulse at edge 7, repeat pulses start HOLD_DELAY later and are 4 cycles apart, direction=1 throughout.
REQ-034 btn_up and btn_down rise together and are held 20 cycles -> no pulses; btn_down released alone -> still no pulse until both are released and pressed again.
REQ-035 rst pulsed during REPEAT with btn_down held -> enable=0, direction=1 next cycle; after rst falls, first pulse 7 edges later with direction=0.
REQ-036 DEBOUNCE=1, REPEAT_PERIOD=1, button held -> enable never high on consecutive cycles; downstream counter driven from 0 steps 0,1,2,... with no skips.
